// File: rtl/rc4_prga_if.sv
`timescale 1ns/1ps
// RC4 PRGA bus bundle: start/busy/finish control, S-memory port, keystream handshake.
// Latency: none, wires only.
// Backpressure: ks_valid/ks_ready carried as-is; memory side has no flow control.
interface rc4_prga_if;
    logic       start;
    logic       busy;
    logic       finish;
    logic [7:0] address;
    logic [7:0] data;
    logic       wren;
    logic [7:0] q;
    logic [7:0] ks_byte;
    logic       ks_valid;
    logic       ks_ready;

    // The keystream generator drives the memory port and the keystream.
    modport master (
        input  start, q, ks_ready,
        output busy, finish, address, data, wren, ks_byte, ks_valid
    );

    // Controller, memory and consumer side.
    modport slave (
        output start, q, ks_ready,
        input  busy, finish, address, data, wren, ks_byte, ks_valid
    );
endinterface

// File: rtl/rc4_prga.sv
`timescale 1ns/1ps
// RC4 keystream generator: walks i/j over S in a single-port RAM, swaps, emits S[si+sj].
// Latency: ks_valid 9 edges after the start-sampling edge; 10 cycles per byte, unstalled.
// Backpressure: waits in EMIT with ks_byte held and the memory port idle until ks_ready.
module rc4_prga #(
    parameter int MSG_LEN = 32
) (
    input logic        clk,
    input logic        reset,
    rc4_prga_if.master bus
);

    localparam logic [8:0] LAST = 9'(MSG_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_I_ADDR, S_I_WAIT, S_I_CAP, S_J_WAIT, S_J_CAP,
        S_WR_I, S_WR_J, S_F_WAIT, S_F_CAP, S_EMIT, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [7:0] addr_q, addr_d, data_q, data_d, ks_q, ks_d;
    logic       wren_q, wren_d, ksv_q, ksv_d;
    logic [8:0] count_q, count_d;

    // Next-state: every memory read is address, wait, capture because the RAM registers its inputs.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = wren_q;
        ks_d    = ks_q;
        ksv_d   = ksv_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    i_d     = '0;
                    j_d     = '0;
                    count_d = '0;
                    state_d = S_I_ADDR;
                end
            end
            S_I_ADDR: begin
                i_d     = i_q + 8'd1;
                addr_d  = i_q + 8'd1;
                state_d = S_I_WAIT;
            end
            S_I_WAIT: state_d = S_I_CAP;
            S_I_CAP: begin
                si_d    = bus.q;
                j_d     = j_q + bus.q;
                addr_d  = j_q + bus.q;
                state_d = S_J_WAIT;
            end
            S_J_WAIT: state_d = S_J_CAP;
            S_J_CAP: begin
                // S[i] <- S[j]; i==j writes the same value twice, which is harmless.
                sj_d    = bus.q;
                addr_d  = i_q;
                data_d  = bus.q;
                wren_d  = 1'b1;
                state_d = S_WR_I;
            end
            S_WR_I: begin
                addr_d  = j_q;
                data_d  = si_q;
                state_d = S_WR_J;
            end
            S_WR_J: begin
                // Both swap writes land before this address is registered, so the
                // final read sees post-swap S even when si+sj hits i or j.
                wren_d  = 1'b0;
                addr_d  = si_q + sj_q;
                state_d = S_F_WAIT;
            end
            S_F_WAIT: state_d = S_F_CAP;
            S_F_CAP: begin
                ks_d    = bus.q;
                ksv_d   = 1'b1;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (bus.ks_ready) begin
                    ksv_d   = 1'b0;
                    count_d = count_q + 9'd1;
                    state_d = (count_q + 9'd1 == LAST) ? S_DONE : S_I_ADDR;
                end
            end
            S_DONE: begin
                // Return the bus outputs to their idle values before IDLE.
                addr_d  = '0;
                data_d  = '0;
                ks_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops wren at once so no write can follow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            ks_q    <= '0;
            ksv_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            ks_q    <= ks_d;
            ksv_q   <= ksv_d;
            count_q <= count_d;
        end
    end

    assign bus.address  = addr_q;
    assign bus.data     = data_q;
    assign bus.wren     = wren_q;
    assign bus.ks_byte  = ks_q;
    assign bus.ks_valid = ksv_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.finish   = (state_q == S_DONE);

endmodule

// File: tb/tb_rc4_prga.sv
`timescale 1ns/1ps
// Bench for rc4_prga: three instances (3, 9, 256 bytes per run) share one S memory.
// Latency: n/a.
// Backpressure: ks_ready driven by the scenario tasks.
module tb_rc4_prga;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       ks_ready = 1'b1;
    logic [1:0] sel = 2'd0;

    always #5 clk = ~clk;

    rc4_prga_if if_a ();
    rc4_prga_if if_b ();
    rc4_prga_if if_c ();

    rc4_prga #(.MSG_LEN(3))   dut_a (.clk(clk), .reset(reset), .bus(if_a));
    rc4_prga #(.MSG_LEN(9))   dut_b (.clk(clk), .reset(reset), .bus(if_b));
    rc4_prga #(.MSG_LEN(256)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    // S memory with registered address and write port
    logic [7:0] smem    [256];
    logic [7:0] pre_mem [256];
    logic       pre_load = 1'b0;
    logic [7:0] mem_addr_r;
    logic [7:0] mem_q;
    logic [7:0] m_addr, m_data, o_byte;
    logic       m_wren, o_valid, o_busy, o_fin;

    assign if_a.start = start && (sel == 2'd0);
    assign if_b.start = start && (sel == 2'd1);
    assign if_c.start = start && (sel == 2'd2);
    assign if_a.q = mem_q;
    assign if_b.q = mem_q;
    assign if_c.q = mem_q;
    assign if_a.ks_ready = ks_ready;
    assign if_b.ks_ready = ks_ready;
    assign if_c.ks_ready = ks_ready;

    always_comb begin
        m_addr  = if_a.address;
        m_data  = if_a.data;
        m_wren  = if_a.wren;
        o_byte  = if_a.ks_byte;
        o_valid = if_a.ks_valid;
        o_busy  = if_a.busy;
        o_fin   = if_a.finish;
        if (sel == 2'd1) begin
            m_addr = if_b.address; m_data = if_b.data; m_wren = if_b.wren;
            o_byte = if_b.ks_byte; o_valid = if_b.ks_valid; o_busy = if_b.busy; o_fin = if_b.finish;
        end else if (sel == 2'd2) begin
            m_addr = if_c.address; m_data = if_c.data; m_wren = if_c.wren;
            o_byte = if_c.ks_byte; o_valid = if_c.ks_valid; o_busy = if_c.busy; o_fin = if_c.finish;
        end
    end

    always @(posedge clk) begin
        if (pre_load) begin
            for (int k = 0; k < 256; k++) smem[k] <= pre_mem[k];
        end else if (m_wren) begin
            smem[m_addr] <= m_data;
        end
        mem_addr_r <= m_addr;
    end
    assign mem_q = smem[mem_addr_r];

    // Monitor: records handshakes, valid rises, finish pulses, and bus activity
    int         edge_cnt = 0;
    logic [7:0] got_b [$];
    int         got_t [$];
    int         rise_t [$];
    int         fin_cnt = 0, last_fin_t = 0, wren_cnt = 0, emit_act = 0, unstable = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_addr = 8'd0, prev_byte = 8'd0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (o_valid === 1'b1 && ks_ready) begin
            got_b.push_back(o_byte);
            got_t.push_back(edge_cnt);
        end
        if (o_valid === 1'b1 && !prev_valid) rise_t.push_back(edge_cnt);
        if (o_fin === 1'b1) begin
            fin_cnt    <= fin_cnt + 1;
            last_fin_t <= edge_cnt;
        end
        if (m_wren === 1'b1) wren_cnt <= wren_cnt + 1;
        if (o_valid === 1'b1 && (m_wren !== 1'b0 || m_addr !== prev_addr)) emit_act <= emit_act + 1;
        if (prev_valid && o_valid === 1'b1 && o_byte !== prev_byte) unstable <= unstable + 1;
        prev_valid <= (o_valid === 1'b1);
        prev_addr  <= m_addr;
        prev_byte  <= o_byte;
    end

    // Software RC4 model and scoreboard
    logic [7:0] ms [256];
    logic [7:0] mi, mj;
    logic [7:0] exp_q [$];
    int checks = 0;
    int fails  = 0;

    task automatic model_identity();
        for (int k = 0; k < 256; k++) ms[k] = 8'(k);
        mi = 8'd0;
        mj = 8'd0;
    endtask

    task automatic model_gen(input int n, input bit push);
        logic [7:0] a, b, t;
        for (int k = 0; k < n; k++) begin
            mi = mi + 8'd1;
            a  = ms[mi];
            mj = mj + a;
            b  = ms[mj];
            ms[mi] = b;
            ms[mj] = a;
            t = a + b;
            if (push) exp_q.push_back(ms[t]);
        end
    endtask

    task automatic load_identity();
        for (int k = 0; k < 256; k++) pre_mem[k] = 8'(k);
        @(posedge clk); #1; pre_load = 1'b1;
        @(posedge clk); #1; pre_load = 1'b0;
    endtask

    task automatic pulse_start(output int t0);
        @(posedge clk); #1;
        start = 1'b1;
        t0 = edge_cnt;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_total(input int target, input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (got_b.size() < target) begin
            @(posedge clk); #1;
            n++;
            if (n > budget) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({m_addr, m_data} !== 16'h0000) begin fails++; $display("FAIL reset_addr_data got=%h want=0000", {m_addr, m_data}); end
        checks++; if ({m_wren, o_valid, o_busy, o_fin} !== 4'b0000) begin fails++; $display("FAIL reset_flags got=%b want=0000", {m_wren, o_valid, o_busy, o_fin}); end
        checks++; if (o_byte !== 8'h00) begin fails++; $display("FAIL reset_ks_byte got=%h want=00", o_byte); end
        checks++; if ({if_b.busy, if_c.busy, if_b.wren, if_c.wren} !== 4'b0000) begin fails++; $display("FAIL reset_other_insts got=%b want=0000", {if_b.busy, if_c.busy, if_b.wren, if_c.wren}); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_identity();
        int b0, r0, f0, w0, t0;
        bit ok;
        logic [7:0] e;
        sel = 2'd0; ks_ready = 1'b1;
        load_identity();
        exp_q.push_back(8'h02); exp_q.push_back(8'h05); exp_q.push_back(8'h07);
        b0 = got_b.size(); r0 = rise_t.size(); f0 = fin_cnt; w0 = wren_cnt;
        pulse_start(t0);
        wait_total(b0 + 3, 100, ok);
        checks++; if (!ok) begin fails++; $display("FAIL ident_timeout got=%0d bytes want=3", got_b.size() - b0); end
        repeat (5) @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            checks++; if (got_b[b0 + k] !== e) begin fails++; $display("FAIL ident_byte%0d got=%h want=%h", k, got_b[b0 + k], e); end
        end
        checks++; if (rise_t[r0] - t0 !== 10) begin fails++; $display("FAIL ident_latency got=%0d want=10", rise_t[r0] - t0); end
        checks++; if (got_t[b0 + 1] - got_t[b0] !== 10 || got_t[b0 + 2] - got_t[b0 + 1] !== 10) begin
            fails++; $display("FAIL ident_period got=%0d,%0d want=10,10", got_t[b0 + 1] - got_t[b0], got_t[b0 + 2] - got_t[b0 + 1]); end
        checks++; if (fin_cnt - f0 !== 1) begin fails++; $display("FAIL ident_finish_count got=%0d want=1", fin_cnt - f0); end
        checks++; if (last_fin_t !== got_t[b0 + 2] + 1) begin fails++; $display("FAIL ident_finish_time got=%0d want=%0d", last_fin_t, got_t[b0 + 2] + 1); end
        checks++; if (wren_cnt - w0 !== 6) begin fails++; $display("FAIL ident_wren_cycles got=%0d want=6", wren_cnt - w0); end
        checks++; if ({smem[2], smem[3], smem[5]} !== 24'h030502) begin fails++; $display("FAIL ident_final_s got=%h want=030502", {smem[2], smem[3], smem[5]}); end
        checks++; if (o_busy !== 1'b0) begin fails++; $display("FAIL ident_idle_busy got=%b want=0", o_busy); end
    endtask

    task automatic test_known_vector();
        logic [7:0] key [3];
        logic [7:0] kv  [9];
        logic [7:0] s   [256];
        logic [7:0] jj, tmp;
        int b0, t0;
        bit ok;
        key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
        kv[0] = 8'hEB; kv[1] = 8'h9F; kv[2] = 8'h77; kv[3] = 8'h81; kv[4] = 8'hB7;
        kv[5] = 8'h34; kv[6] = 8'hCA; kv[7] = 8'h72; kv[8] = 8'hA7;
        for (int k = 0; k < 256; k++) s[k] = 8'(k);
        jj = 8'd0;
        for (int k = 0; k < 256; k++) begin
            jj = jj + s[k] + key[k % 3];
            tmp = s[k]; s[k] = s[jj]; s[jj] = tmp;
        end
        for (int k = 0; k < 256; k++) pre_mem[k] = s[k];
        for (int k = 0; k < 9; k++) exp_q.push_back(kv[k]);
        sel = 2'd1; ks_ready = 1'b1;
        @(posedge clk); #1; pre_load = 1'b1;
        @(posedge clk); #1; pre_load = 1'b0;
        b0 = got_b.size();
        pulse_start(t0);
        wait_total(b0 + 9, 200, ok);
        checks++; if (!ok) begin fails++; $display("FAIL key_timeout got=%0d bytes want=9", got_b.size() - b0); end
        for (int k = 0; k < 9; k++) begin
            kv[k] = exp_q.pop_front();
            checks++; if (got_b[b0 + k] !== kv[k]) begin fails++; $display("FAIL key_byte%0d got=%h want=%h", k, got_b[b0 + k], kv[k]); end
        end
        repeat (5) @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int b0, u0, a0, f0, t0, n, stall;
        logic [7:0] e;
        sel = 2'd0; ks_ready = 1'b1;
        load_identity();
        exp_q.push_back(8'h02); exp_q.push_back(8'h05); exp_q.push_back(8'h07);
        b0 = got_b.size(); u0 = unstable; a0 = emit_act; f0 = fin_cnt;
        pulse_start(t0);
        n = 0; stall = 0;
        while (got_b.size() < b0 + 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (o_valid) begin
                if (stall < 5) begin ks_ready = 1'b0; stall++; end
                else ks_ready = 1'b1;
            end else begin
                ks_ready = 1'b1;
                stall = 0;
            end
        end
        ks_ready = 1'b1;
        checks++; if (got_b.size() < b0 + 3) begin fails++; $display("FAIL bp_timeout got=%0d bytes want=3", got_b.size() - b0); end
        repeat (5) @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            checks++; if (got_b[b0 + k] !== e) begin fails++; $display("FAIL bp_byte%0d got=%h want=%h", k, got_b[b0 + k], e); end
        end
        checks++; if (got_t[b0 + 1] - got_t[b0] !== 15 || got_t[b0 + 2] - got_t[b0 + 1] !== 15) begin
            fails++; $display("FAIL bp_period got=%0d,%0d want=15,15", got_t[b0 + 1] - got_t[b0], got_t[b0 + 2] - got_t[b0 + 1]); end
        checks++; if (unstable - u0 !== 0) begin fails++; $display("FAIL bp_byte_stable got=%0d changes want=0", unstable - u0); end
        checks++; if (emit_act - a0 !== 0) begin fails++; $display("FAIL bp_emit_mem_idle got=%0d events want=0", emit_act - a0); end
        checks++; if (fin_cnt - f0 !== 1) begin fails++; $display("FAIL bp_finish_count got=%0d want=1", fin_cnt - f0); end
    endtask

    task automatic test_start_while_busy();
        int b0, r0, f0, t0;
        bit ok;
        logic [7:0] e;
        sel = 2'd0; ks_ready = 1'b1;
        load_identity();
        exp_q.push_back(8'h02); exp_q.push_back(8'h05); exp_q.push_back(8'h07);
        b0 = got_b.size(); r0 = rise_t.size(); f0 = fin_cnt;
        pulse_start(t0);
        repeat (3) @(posedge clk);
        #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_total(b0 + 3, 100, ok);
        checks++; if (!ok) begin fails++; $display("FAIL swb_timeout got=%0d bytes want=3", got_b.size() - b0); end
        repeat (20) @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            checks++; if (got_b[b0 + k] !== e) begin fails++; $display("FAIL swb_byte%0d got=%h want=%h", k, got_b[b0 + k], e); end
        end
        checks++; if (got_t[b0] - t0 !== 10 || got_t[b0 + 2] - got_t[b0] !== 20) begin
            fails++; $display("FAIL swb_timing got=%0d,%0d want=10,20", got_t[b0] - t0, got_t[b0 + 2] - got_t[b0]); end
        checks++; if (rise_t.size() - r0 !== 3 || fin_cnt - f0 !== 1) begin
            fails++; $display("FAIL swb_no_rerun got=%0d rises,%0d finishes want=3,1", rise_t.size() - r0, fin_cnt - f0); end
    endtask

    task automatic test_reset_mid_run();
        int b0, t0, n, rises, bad;
        bit ok, pw;
        logic [7:0] e;
        sel = 2'd0; ks_ready = 1'b1;
        load_identity();
        model_identity();
        model_gen(2, 1'b0);
        pulse_start(t0);
        n = 0; rises = 0; pw = 1'b0;
        while (rises < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (m_wren && !pw) rises++;
            pw = m_wren;
        end
        checks++; if (rises != 3) begin fails++; $display("FAIL rst_reach_wr_i got=%0d wren rises want=3", rises); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({m_wren, o_valid, o_busy} !== 3'b000) begin fails++; $display("FAIL rst_immediate got=%b want=000", {m_wren, o_valid, o_busy}); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (o_busy !== 1'b0) begin fails++; $display("FAIL rst_idle got busy=%b want=0", o_busy); end
        bad = 0;
        for (int k = 0; k < 256; k++) if (smem[k] !== ms[k]) bad++;
        checks++; if (bad != 0) begin fails++; $display("FAIL rst_no_write got=%0d differing words want=0", bad); end
        mi = 8'd0; mj = 8'd0;
        model_gen(3, 1'b1);
        b0 = got_b.size();
        pulse_start(t0);
        wait_total(b0 + 3, 100, ok);
        checks++; if (!ok) begin fails++; $display("FAIL rst_rerun_timeout got=%0d bytes want=3", got_b.size() - b0); end
        repeat (5) @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            checks++; if (got_b[b0 + k] !== e) begin fails++; $display("FAIL rst_rerun_byte%0d got=%h want=%h", k, got_b[b0 + k], e); end
        end
    endtask

    task automatic test_wrap();
        int b0, r0, f0, t0, bad;
        bit ok;
        logic [7:0] e;
        sel = 2'd2; ks_ready = 1'b1;
        load_identity();
        model_identity();
        model_gen(256, 1'b1);
        b0 = got_b.size(); r0 = rise_t.size(); f0 = fin_cnt;
        pulse_start(t0);
        wait_total(b0 + 256, 3000, ok);
        checks++; if (!ok) begin fails++; $display("FAIL wrap_timeout got=%0d bytes want=256", got_b.size() - b0); end
        repeat (30) @(posedge clk); #1;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            e = exp_q.pop_front();
            if (got_b[b0 + k] !== e) begin
                if (bad < 4) $display("  wrap byte %0d got=%h want=%h", k, got_b[b0 + k], e);
                bad++;
            end
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL wrap_bytes got=%0d wrong want=0", bad); end
        checks++; if (got_b.size() - b0 !== 256) begin fails++; $display("FAIL wrap_handshakes got=%0d want=256", got_b.size() - b0); end
        checks++; if (fin_cnt - f0 !== 1 || rise_t.size() - r0 !== 256) begin
            fails++; $display("FAIL wrap_finish got=%0d finishes,%0d rises want=1,256", fin_cnt - f0, rise_t.size() - r0); end
        checks++; if (o_busy !== 1'b0) begin fails++; $display("FAIL wrap_idle got busy=%b want=0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_known_vector();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_run();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
